// File: rtl/mdu_core.sv
// Multiply/divide unit beside the execute-stage ALU: computes MULT/MULTU/DIV/DIVU up front,
// holds the result for a configurable latency, then commits it to HI/LO. Also serves MTHI/MTLO.
module mdu_core #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       MDUOp,
    input  logic             Start,
    input  logic [WIDTH-1:0] MD_A,
    input  logic [WIDTH-1:0] MD_B,
    input  logic             ReadHi,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MDU_Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {IDLE, RUN} state_e;

    mdu_op_e op;
    assign op = mdu_op_e'(MDUOp);

    // Signed multiply is an unsigned multiply of sign-extended operands, truncated to 2*WIDTH.
    logic               mul_signed;
    logic [2*WIDTH-1:0] mul_a, mul_b, product;

    assign mul_signed = (op == OP_MULT);
    assign mul_a      = {{WIDTH{mul_signed & MD_A[WIDTH-1]}}, MD_A};
    assign mul_b      = {{WIDTH{mul_signed & MD_B[WIDTH-1]}}, MD_B};
    assign product    = mul_a * mul_b;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend.
    logic             div_signed, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, div_b, q_mag, r_mag;
    logic [WIDTH-1:0] div_hi, div_lo;

    assign div_signed = (op == OP_DIV);
    assign a_neg      = div_signed & MD_A[WIDTH-1];
    assign b_neg      = div_signed & MD_B[WIDTH-1];
    assign mag_a      = a_neg ? -MD_A : MD_A;
    assign mag_b      = b_neg ? -MD_B : MD_B;
    assign div_b      = (MD_B == '0) ? WIDTH'(1) : mag_b;
    assign q_mag      = mag_a / div_b;
    assign r_mag      = mag_a % div_b;

    always_comb begin
        div_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
        div_hi = a_neg ? -r_mag : r_mag;
        if (MD_B == '0) begin
            div_lo = '1;
            div_hi = MD_A;
        end else if (div_signed && MD_A == MOST_NEG && MD_B == '1) begin
            div_lo = MD_A;
            div_hi = '0;
        end
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d   = state_q;
        count_d   = count_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = product;
                            count_d = CNT_W'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = div_hi;
                            pend_lo_d = div_lo;
                            count_d   = CNT_W'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = MD_A;
                        OP_MTLO: lo_d = MD_A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Start is ignored here; the pipeline holds the request until Busy drops.
                if (count_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            count_q   <= count_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign Busy    = (state_q == RUN);
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign MDU_Out = ReadHi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_core.sv
// Self-checking bench for mdu_core: randomized and directed requests compared against a
// plain-arithmetic reference model of HI/LO results and busy latency.
module tb_mdu_core;

    localparam int WIDTH  = 32;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       MDUOp;
    logic             Start;
    logic [WIDTH-1:0] MD_A, MD_B;
    logic             ReadHi;
    logic             Busy;
    logic [WIDTH-1:0] HI, LO, MDU_Out;

    always #5 clk = ~clk;

    mdu_core #(.WIDTH(WIDTH), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .MDUOp  (MDUOp),
        .Start  (Start),
        .MD_A   (MD_A),
        .MD_B   (MD_B),
        .ReadHi (ReadHi),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO),
        .MDU_Out(MDU_Out)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    req_t        req_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_hi, exp_lo;

    // Reference model: the architectural result of each request, in plain integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        int              sa, sb;
        longint          p;
        longint unsigned pu;
        sa = a;
        sb = b;
        h  = exp_hi;
        l  = exp_lo;
        case (op)
            OP_MULT: begin
                p = longint'(sa) * longint'(sb);
                {h, l} = p;
            end
            OP_MULTU: begin
                pu = longint'(a) * longint'(b);
                {h, l} = pu;
            end
            OP_DIV: begin
                if (b == 32'h0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = a; h = 32'h0;
                end else begin
                    l = sa / sb; h = sa % sb;
                end
            end
            OP_DIVU: begin
                if (b == 32'h0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else begin
                    l = a / b; h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Called just after a falling edge; drives one request, returns busy length and whether
    // HI/LO moved away from the pre-operation values while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output bit stale);
        Start = 1'b1;
        MDUOp = op;
        MD_A  = a;
        MD_B  = b;
        @(negedge clk);
        Start  = 1'b0;
        MDUOp  = OP_NOP;
        cycles = 0;
        stale  = 1'b0;
        while (Busy && cycles < 40) begin
            cycles++;
            if (HI !== exp_hi || LO !== exp_lo) stale = 1'b1;
            @(negedge clk);
        end
    endtask

    // Runs every queued request back to back and checks latency, results and the read mux.
    task automatic run_batch(input string tag);
        req_t        r;
        logic [31:0] mh, ml;
        int          cyc, want;
        bit          stale;
        while (req_q.size() > 0) begin
            r = req_q.pop_front();
            model(r.op, r.a, r.b, mh, ml);
            want = (r.op == OP_MULT || r.op == OP_MULTU) ? MULT_N : DIV_N;
            run_op(r.op, r.a, r.b, cyc, stale);
            n_cmp++;
            if (cyc != want) begin
                n_bad++;
                $display("FAIL %s busy_cycles op=%0d a=%h b=%h got %0d want %0d", tag, r.op, r.a, r.b, cyc, want);
            end
            n_cmp++;
            if (stale) begin
                n_bad++;
                $display("FAIL %s hilo_during_run op=%0d got changed want held %h/%h", tag, r.op, exp_hi, exp_lo);
            end
            n_cmp++;
            if (HI !== mh) begin
                n_bad++;
                $display("FAIL %s hi op=%0d a=%h b=%h got %h want %h", tag, r.op, r.a, r.b, HI, mh);
            end
            n_cmp++;
            if (LO !== ml) begin
                n_bad++;
                $display("FAIL %s lo op=%0d a=%h b=%h got %h want %h", tag, r.op, r.a, r.b, LO, ml);
            end
            ReadHi = 1'b1;
            #1;
            n_cmp++;
            if (MDU_Out !== mh) begin
                n_bad++;
                $display("FAIL %s mdu_out_hi got %h want %h", tag, MDU_Out, mh);
            end
            ReadHi = 1'b0;
            #1;
            n_cmp++;
            if (MDU_Out !== ml) begin
                n_bad++;
                $display("FAIL %s mdu_out_lo got %h want %h", tag, MDU_Out, ml);
            end
            exp_hi = mh;
            exp_lo = ml;
        end
    endtask

    function automatic logic [31:0] rand_divisor();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'($urandom_range(1, 20));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        reset  = 1'b1;
        Start  = 1'b0;
        MDUOp  = OP_NOP;
        MD_A   = '0;
        MD_B   = '0;
        ReadHi = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", Busy); end
        n_cmp++;
        if (HI !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", HI); end
        n_cmp++;
        if (LO !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", LO); end
        n_cmp++;
        if (MDU_Out !== 32'h0) begin n_bad++; $display("FAIL reset_out got %h want 0", MDU_Out); end
        reset  = 1'b0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
    endtask

    task automatic test_directed();
        req_q.push_back('{OP_MULT,  32'hFFFF_FFFE, 32'h3});
        req_q.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        req_q.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h2});
        req_q.push_back('{OP_DIVU,  32'h7,         32'h2});
        req_q.push_back('{OP_DIVU,  32'h5,         32'h0});
        req_q.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF});
        req_q.push_back('{OP_DIV,   32'h8000_0000, 32'h0});
        req_q.push_back('{OP_MULT,  32'h8000_0000, 32'h8000_0000});
        run_batch("directed");
    endtask

    task automatic test_mult();
        for (int i = 0; i < 8; i++)
            req_q.push_back('{($urandom_range(0, 1) != 0) ? OP_MULT : OP_MULTU, $urandom, $urandom});
        run_batch("mult");
    endtask

    task automatic test_div();
        for (int i = 0; i < 10; i++) begin
            if (i == 4) req_q.push_back('{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF});
            else req_q.push_back('{($urandom_range(0, 1) != 0) ? OP_DIV : OP_DIVU, $urandom, rand_divisor()});
        end
        run_batch("div");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            req_q.push_back('{3'($urandom_range(1, 4)), $urandom, rand_divisor()});
        run_batch("back_to_back");
    endtask

    task automatic test_ignore_start();
        logic [31:0] a, b, mh, ml;
        int          cyc;
        a = $urandom;
        b = $urandom;
        model(OP_MULT, a, b, mh, ml);
        Start = 1'b1;
        MDUOp = OP_MULT;
        MD_A  = a;
        MD_B  = b;
        @(negedge clk);
        MDUOp = OP_MTHI;
        MD_A  = 32'h1234;
        MD_B  = 32'h0;
        cyc   = 0;
        while (Busy && cyc < 40) begin
            cyc++;
            if (cyc == 2) MDUOp = OP_DIV;
            if (cyc == 4) begin Start = 1'b0; MDUOp = OP_NOP; end
            @(negedge clk);
        end
        n_cmp++;
        if (cyc != MULT_N) begin n_bad++; $display("FAIL ignore_busy got %0d want %0d", cyc, MULT_N); end
        n_cmp++;
        if (HI !== mh) begin n_bad++; $display("FAIL ignore_hi got %h want %h", HI, mh); end
        n_cmp++;
        if (LO !== ml) begin n_bad++; $display("FAIL ignore_lo got %h want %h", LO, ml); end
        exp_hi = mh;
        exp_lo = ml;

        Start = 1'b1;
        MDUOp = OP_MTLO;
        MD_A  = 32'hABCD;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = OP_NOP;
        n_cmp++;
        if (Busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy got %b want 0", Busy); end
        n_cmp++;
        if (LO !== 32'hABCD) begin n_bad++; $display("FAIL mtlo_lo got %h want 0000abcd", LO); end
        n_cmp++;
        if (HI !== exp_hi) begin n_bad++; $display("FAIL mtlo_hi got %h want %h", HI, exp_hi); end
        ReadHi = 1'b0;
        #1;
        n_cmp++;
        if (MDU_Out !== 32'hABCD) begin n_bad++; $display("FAIL mtlo_out got %h want 0000abcd", MDU_Out); end
        exp_lo = 32'hABCD;
        @(negedge clk);
        Start = 1'b1;
        MDUOp = OP_MTHI;
        MD_A  = 32'h1234;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = OP_NOP;
        n_cmp++;
        if (HI !== 32'h1234 || LO !== exp_lo) begin
            n_bad++;
            $display("FAIL mthi_idle got %h/%h want 00001234/%h", HI, LO, exp_lo);
        end
        exp_hi = 32'h1234;
    endtask

    task automatic test_nop();
        logic [2:0] ops[3];
        logic       strobes[3];
        ops     = '{OP_NOP, OP_RSVD, OP_MULT};
        strobes = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            Start = strobes[i];
            MDUOp = ops[i];
            MD_A  = $urandom;
            MD_B  = $urandom;
            @(negedge clk);
            n_cmp++;
            if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
                n_bad++;
                $display("FAIL nop_%0d got busy=%b %h/%h want busy=0 %h/%h", i, Busy, HI, LO, exp_hi, exp_lo);
            end
        end
        Start = 1'b0;
        MDUOp = OP_NOP;
    endtask

    task automatic test_reset_mid_run();
        bit quiet_ok;
        Start = 1'b1;
        MDUOp = OP_DIV;
        MD_A  = $urandom;
        MD_B  = 32'h7;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = OP_NOP;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (Busy !== 1'b1) begin n_bad++; $display("FAIL midrun_busy_before got %b want 1", Busy); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            n_bad++;
            $display("FAIL midrun_abort got busy=%b %h/%h want busy=0 0/0", Busy, HI, LO);
        end
        @(negedge clk);
        reset    = 1'b0;
        exp_hi   = 32'h0;
        exp_lo   = 32'h0;
        quiet_ok = 1'b1;
        for (int i = 0; i < DIV_N + 4; i++) begin
            @(negedge clk);
            if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) quiet_ok = 1'b0;
        end
        n_cmp++;
        if (!quiet_ok) begin n_bad++; $display("FAIL midrun_no_commit got late activity want idle 0/0"); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_q.push_back('{OP_MULT, $urandom, $urandom});
        run_batch("after_reset");
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        @(negedge clk);
        test_directed();
        test_mult();
        test_div();
        test_back_to_back();
        test_ignore_start();
        @(negedge clk);
        test_nop();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_core.md
# mdu_core

Parametrised multiply/divide unit for the pipelined MIPS core, sitting beside the execute-stage ALU. It accepts signed/unsigned multiply and divide requests, runs them over a configurable number of cycles, and commits results to internal HI/LO registers. It signals Busy so hazard logic can stall, and serves MTHI/MTLO/MFHI/MFLO directly. WIDTH generalises the datapath beyond 32 bits.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- MDUOp  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
- Start  input  1  request strobe; qualifies MDUOp for ops 1–6
- MD_A  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
- MD_B  input  WIDTH  rt operand (divisor / multiplier)
- ReadHi  input  1  1 selects HI onto MDU_Out, 0 selects LO
- Busy  output  1  operation in flight
- HI  output  WIDTH  committed HI register
- LO  output  WIDTH  committed LO register
- MDU_Out  output  WIDTH  combinational ReadHi ? HI : LO (MFHI/MFLO path)

## Operation
- States: IDLE, RUN. Reset → IDLE, HI=0, LO=0, Busy=0, counter=0, pending regs=0.
- IDLE, Start=1, MDUOp∈{1..4}: compute full result from MD_A/MD_B into pending HI/LO regs, load counter with MULT_CYCLES or DIV_CYCLES, go RUN.
  - MULT: {HI,LO} = signed 2·WIDTH product. MULTU: unsigned product.
  - DIV: LO = signed quotient (truncate toward zero), HI = remainder with sign of dividend. DIVU: unsigned.
  - Divide by zero (MD_B=0): LO = all ones, HI = MD_A. Signed overflow (MD_A = most-negative, MD_B = −1): LO = MD_A, HI = 0.
- RUN: counter decrements each cycle; when counter reaches 1, next edge writes pending regs to HI/LO, clears Busy, returns to IDLE.
- IDLE, Start=1, MDUOp=5/6: HI/LO ← MD_A at that edge; no Busy.
- Start while RUN: ignored entirely (operands, op, HI/LO untouched). Upstream stall logic must hold the instruction.
- Start=0 or MDUOp∈{0,7}: no state change.
- HI/LO change only at commit, MTHI/MTLO, or reset.

## Timing
- Start sampled at edge E0. Busy=1 from after E0 through N cycles (N = MULT_CYCLES/DIV_CYCLES); at edge EN HI/LO take new values and Busy falls together.
- Hazard logic stalls MFHI/MFLO/mult-div on (Start & MDUOp∈{1..4}) | Busy; Start itself is not registered for that purpose.
- MDU_Out is combinational from ReadHi and committed HI/LO; during RUN it returns pre-operation values.
- Back-to-back: new Start accepted at EN+... i.e. first edge with Busy=0 sampled low (cycle after commit); commit and new Start never coincide.
- Reset asserted mid-RUN: immediately aborts, pending result discarded, HI=LO=0, Busy=0; first request accepted on first edge after reset deasserts.

## Test plan
- Reset, then MULT MD_A=0xFFFFFFFE (−2), MD_B=3 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 then DIVU 7/2 -> Busy 10 cycles each; LO=0xFFFFFFFD, HI=0xFFFFFFFF; then LO=3, HI=1.
- DIVU 5/0 and DIV 0x80000000/0xFFFFFFFF -> LO=0xFFFFFFFF, HI=5; then LO=0x80000000, HI=0.
- MTHI 0x1234 during RUN of a MULT -> ignored; HI equals product high word at commit; MTLO 0xABCD in IDLE -> LO=0xABCD next cycle, ReadHi=0 gives MDU_Out=0xABCD.
- Assert reset 3 cycles into a DIV -> Busy=0, HI=LO=0 immediately; no later commit occurs.
